// File: rtl/mul_acc.sv
// Multiply-accumulate stage: sums a programmed number of unsigned products into a registered accumulator.
// Optional build macro MUL_ACC_SAT_EN makes the accumulator saturate on carry instead of wrapping.
module mul_acc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] product,
  output logic [WIDTH-1:0] acc_out,
  output logic             done,
  output logic             busy,
  output logic             ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic             r_ovf;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_len;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_acc_nxt;

  assign w_accept = in_valid && (r_state == S_ACC);
  assign w_sum    = {1'b0, r_acc} + {1'b0, product};
  // r_len is never zero while in ACC, so len-1 cannot underflow here
  assign w_last   = (r_cnt == r_len - CNT_W'(1));

`ifdef MUL_ACC_SAT_EN
  // A saturated accumulator carries out on any non-zero product, so it stays all ones
  assign w_acc_nxt = w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
`else
  assign w_acc_nxt = w_sum[WIDTH-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = (len == '0) ? S_DONE : S_ACC;
      S_ACC:   if (w_accept && w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake and status come from the state register only
  always_comb begin
    in_ready = (r_state == S_ACC);
    done     = (r_state == S_DONE);
    busy     = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_cnt <= '0;
      r_len <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_acc <= '0;
        r_ovf <= 1'b0;
        r_cnt <= '0;
        r_len <= len;
      end else if (w_accept) begin
        r_acc <= w_acc_nxt;
        r_ovf <= r_ovf | w_sum[WIDTH];
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign acc_out = r_acc;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_mul_acc.sv
// Scoreboard bench for mul_acc: stimulus pushes expected results, a negedge monitor checks each done pulse.
module tb_mul_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] product;
  logic [31:0] acc_out;
  logic        done;
  logic        busy;
  logic        ovf;

  mul_acc #(.WIDTH(32), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .product(product),
    .acc_out(acc_out), .done(done), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] acc;
    logic        ovf;
    int          edge_n;
  } exp_t;

  exp_t        q[$];
  int          edges = 0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] prods [0:255];
  bit          prev_done = 0;

  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edges);
    end
  endtask

  // Reference: the whole accumulation is an unbounded sum of unsigned products
  function automatic exp_t model(input longint unsigned tot, input int edge_n);
    exp_t e;
    e.ovf = (tot >> 32) != 0;
`ifdef MUL_ACC_SAT_EN
    e.acc = e.ovf ? 32'hFFFF_FFFF : tot[31:0];
`else
    e.acc = tot[31:0];
`endif
    e.edge_n = edge_n;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_done = 0;
    end else begin
      if (prev_done) begin
        chk("done_one_cycle", {63'd0, done}, 64'd0);
        chk("busy_after_done", {63'd0, busy}, 64'd0);
      end
      if (done) begin
        if (q.size() == 0) begin
          chk("spurious_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("acc_out", {32'd0, acc_out}, {32'd0, e.acc});
          chk("ovf", {63'd0, ovf}, {63'd0, e.ovf});
          chk("done_edge", 64'(edges), 64'(e.edge_n));
        end
      end
      prev_done = done;
    end
  end

  // Runs one accumulation over prods[0..L-1]; gaps insert idle cycles, poke drives start/len while busy
  task automatic run_acc(input int L, input int gap_pct, input bit poke);
    longint unsigned tot = 0;
    @(negedge clk);
    start = 1'b1;
    len   = 8'(L);
    if (L == 0) begin
      q.push_back(model(0, edges + 1));
      @(negedge clk);
      start = 1'b0;
      chk("len0_in_ready", {63'd0, in_ready}, 64'd0);
      @(negedge clk);
      chk("len0_in_ready_after", {63'd0, in_ready}, 64'd0);
      return;
    end
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    for (int i = 0; i < L; i++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        product  = $urandom;
        if (poke) begin
          start = 1'b1;
          len   = 8'($urandom);
        end
        chk("in_ready_gap", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
      end
      start    = 1'b0;
      in_valid = 1'b1;
      product  = prods[i];
      tot     += prods[i];
      chk("in_ready_acc", {63'd0, in_ready}, 64'd1);
      if (i == L - 1) q.push_back(model(tot, edges + 1));
      @(negedge clk);
    end
    in_valid = 1'b0;
    product  = 32'd0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0; product = 32'd0;
    #1;
    chk("rst_acc", {32'd0, acc_out}, 64'd0);
    chk("rst_flags", {59'd0, ovf, done, busy, in_ready}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    prods[0] = 32'd54; prods[1] = 32'd136530; prods[2] = 32'd1234567800;
    run_acc(3, 0, 0);
    chk("dir_sum3", {32'd0, acc_out}, 64'd1234704384);
    chk("dir_sum3_ovf", {63'd0, ovf}, 64'd0);

    prods[0] = 32'hFFFF_FFFF; prods[1] = 32'hFFFF_FFF6;
    run_acc(2, 0, 0);
`ifdef MUL_ACC_SAT_EN
    chk("dir_ovf_acc", {32'd0, acc_out}, 64'hFFFF_FFFF);
`else
    chk("dir_ovf_acc", {32'd0, acc_out}, 64'hFFFF_FFF5);
`endif
    chk("dir_ovf_flag", {63'd0, ovf}, 64'd1);

    run_acc(0, 0, 0);
    chk("dir_len0_acc", {32'd0, acc_out}, 64'd0);

    // Toggled valid with start pulses mid-accumulation
    prods[0] = 32'd6; prods[1] = 32'd9;
    @(negedge clk);
    start = 1'b1; len = 8'd2;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; product = 32'd6;
    @(negedge clk);
    in_valid = 1'b0; product = 32'd77; start = 1'b1; len = 8'd5;
    @(negedge clk);
    start = 1'b0; product = 32'd88;
    @(negedge clk);
    in_valid = 1'b1; product = 32'd9;
    q.push_back(model(15, edges + 1));
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("dir_toggle_acc", {32'd0, acc_out}, 64'd15);

    // Product presented while idle must be ignored
    in_valid = 1'b1; product = 32'd100;
    @(negedge clk); @(negedge clk);
    in_valid = 1'b0;
    prods[0] = 32'd5;
    run_acc(1, 0, 0);
    chk("dir_idle_ignore", {32'd0, acc_out}, 64'd5);

    // Reset mid-accumulation
    @(negedge clk);
    start = 1'b1; len = 8'd3;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; product = 32'd1000;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_acc", {32'd0, acc_out}, 64'd0);
    chk("midrst_flags", {59'd0, ovf, done, busy, in_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    prods[0] = 32'd7;
    run_acc(1, 0, 0);
    chk("after_rst_acc", {32'd0, acc_out}, 64'd7);
    chk("after_rst_ovf", {63'd0, ovf}, 64'd0);

    // Randomized accumulations
    for (int r = 0; r < 30; r++) begin
      int L;
      bit big;
      L   = (r == 29) ? 255 : int'($urandom_range(0, 12));
      big = $urandom_range(0, 1) == 1;
      for (int i = 0; i < L; i++)
        prods[i] = big ? $urandom : $urandom_range(0, 100000);
      run_acc(L, (r % 3 == 0) ? 0 : 30, r % 2 == 1);
    end

    @(negedge clk); @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
